// File: rtl/lmc_pkg.sv
// Shared constants, command codes, gain ROM and arithmetic helpers for the LMC1992 mixer model.
package lmc_pkg;

    localparam int unsigned OUT_W = 16;
    localparam int unsigned SR_W  = 11;

    localparam logic [1:0] LMC_ADDR = 2'b10;

    typedef enum logic [2:0] {
        LMC_FN_MIX    = 3'd0,
        LMC_FN_BASS   = 3'd1,
        LMC_FN_TREBLE = 3'd2,
        LMC_FN_MASTER = 3'd3,
        LMC_FN_RIGHT  = 3'd4,
        LMC_FN_LEFT   = 3'd5
    } lmc_fn_e;

    localparam logic [1:0] LMC_MIX_DEF    = 2'b01;
    localparam logic [3:0] LMC_TONE_DEF   = 4'd6;
    localparam logic [5:0] LMC_MASTER_DEF = 6'd40;
    localparam logic [5:0] LMC_LR_DEF     = 6'd20;

    localparam logic [5:0] LMC_TONE_MAX   = 6'd12;
    localparam logic [5:0] LMC_MASTER_MAX = 6'd40;
    localparam logic [5:0] LMC_LR_MAX     = 6'd20;

    // round(256 * 10^(-n/10)), one entry per 2 dB attenuation step
    localparam logic [8:0] LMC_GAIN_ROM [0:39] = '{
        9'd256, 9'd203, 9'd162, 9'd128, 9'd102, 9'd81,  9'd64,  9'd51,  9'd41,  9'd32,
        9'd26,  9'd20,  9'd16,  9'd13,  9'd10,  9'd8,   9'd6,   9'd5,   9'd4,   9'd3,
        9'd3,   9'd2,   9'd2,   9'd1,   9'd1,   9'd1,   9'd1,   9'd1,   9'd0,   9'd0,
        9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0,   9'd0
    };

    function automatic logic [8:0] lmc_gain(input logic [6:0] n);
        if (n >= 7'd40) return 9'd0;
        return LMC_GAIN_ROM[6'(n)];
    endfunction

    function automatic logic [5:0] lmc_clip(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [15:0] lmc_sat(input logic signed [18:0] x);
        if (x > 19'sd32767)  return 16'h7fff;
        if (x < -19'sd32768) return 16'h8000;
        return x[15:0];
    endfunction

endpackage

// File: rtl/lmc_mw_rx.sv
// Microwire receiver: edge-detects clock/done levels, shifts in up to 11 bits, emits addressed commands.
module lmc_mw_rx
    import lmc_pkg::*;
(
    input  logic       clk32,
    input  logic       resb,
    input  logic       i_mw_clk,
    input  logic       i_mw_data,
    input  logic       i_mw_done,
    output logic       o_cmd_valid,
    output logic [2:0] o_fn,
    output logic [5:0] o_val
);

    logic        r_clk_d;
    logic        r_done_d;
    logic [10:0] r_sr;
    logic [3:0]  r_cnt;

    logic        w_clk_rise;
    logic        w_done_rise;
    logic [10:0] w_sr_nxt;
    logic [3:0]  w_cnt_nxt;

    assign w_clk_rise  = i_mw_clk  & ~r_clk_d;
    assign w_done_rise = i_mw_done & ~r_done_d;

    // Shift happens before evaluation so a bit arriving with done is included
    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_cnt;
        if (w_clk_rise) begin
            w_sr_nxt = {r_sr[9:0], i_mw_data};
            if (r_cnt != 4'(SR_W)) w_cnt_nxt = r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk32) begin
        if (!resb) begin
            r_clk_d     <= 1'b0;
            r_done_d    <= 1'b0;
            r_sr        <= '0;
            r_cnt       <= '0;
            o_cmd_valid <= 1'b0;
            o_fn        <= '0;
            o_val       <= '0;
        end else begin
            r_clk_d     <= i_mw_clk;
            r_done_d    <= i_mw_done;
            r_sr        <= w_sr_nxt;
            r_cnt       <= w_done_rise ? 4'd0 : w_cnt_nxt;
            o_cmd_valid <= w_done_rise && (w_cnt_nxt == 4'(SR_W)) && (w_sr_nxt[10:9] == LMC_ADDR);
            o_fn        <= w_sr_nxt[8:6];
            o_val       <= w_sr_nxt[5:0];
        end
    end

endmodule

// File: rtl/lmc_audio_mixer.sv
// LMC1992-style mixer: microwire-controlled registers, DMA/PSG mixing and 2-stage volume pipeline.
module lmc_audio_mixer
    import lmc_pkg::*;
(
    input  logic             clk32,
    input  logic             resb,
    input  logic             MW_CLK,
    input  logic             MW_DATA,
    input  logic             MW_DONE,
    input  logic             SAMPLE_EN,
    input  logic [7:0]       DMA_L,
    input  logic [7:0]       DMA_R,
    input  logic [7:0]       PSG_IN,
    output logic [OUT_W-1:0] OUT_L,
    output logic [OUT_W-1:0] OUT_R,
    output logic             OUT_VALID,
    output logic [3:0]       BASS,
    output logic [3:0]       TREBLE
);

    logic        w_cmd_valid;
    logic [2:0]  w_fn;
    logic [5:0]  w_val;

    logic [1:0]  r_mix;
    logic [3:0]  r_bass;
    logic [3:0]  r_treble;
    logic [5:0]  r_master;
    logic [5:0]  r_left;
    logic [5:0]  r_right;

    logic        r_v1;
    logic [8:0]  r_m_l;
    logic [8:0]  r_m_r;
    logic [8:0]  r_g_l;
    logic [8:0]  r_g_r;

    logic signed [7:0]  w_s_l;
    logic signed [7:0]  w_s_r;
    logic signed [7:0]  w_p;
    logic signed [7:0]  w_p_add;
    logic [8:0]         w_m_l;
    logic [8:0]         w_m_r;
    logic [6:0]         w_att_l;
    logic [6:0]         w_att_r;
    logic signed [18:0] w_prod_l;
    logic signed [18:0] w_prod_r;

    lmc_mw_rx u_mw_rx (
        .clk32       (clk32),
        .resb        (resb),
        .i_mw_clk    (MW_CLK),
        .i_mw_data   (MW_DATA),
        .i_mw_done   (MW_DONE),
        .o_cmd_valid (w_cmd_valid),
        .o_fn        (w_fn),
        .o_val       (w_val)
    );

    // Offset binary to two's complement is a flip of the msb
    assign w_s_l = {~DMA_L[7],  DMA_L[6:0]};
    assign w_s_r = {~DMA_R[7],  DMA_R[6:0]};
    assign w_p   = {~PSG_IN[7], PSG_IN[6:0]};

    always_comb begin
        w_p_add = 8'sd0;
        case (r_mix)
            2'b01:   w_p_add = w_p;
            2'b00:   w_p_add = w_p >>> 2;
            default: w_p_add = 8'sd0;
        endcase
    end

    assign w_m_l = {w_s_l[7], w_s_l} + {w_p_add[7], w_p_add};
    assign w_m_r = {w_s_r[7], w_s_r} + {w_p_add[7], w_p_add};

    assign w_att_l = 7'(LMC_MASTER_MAX - r_master) + 7'(LMC_LR_MAX - r_left);
    assign w_att_r = 7'(LMC_MASTER_MAX - r_master) + 7'(LMC_LR_MAX - r_right);

    assign w_prod_l = $signed({{10{r_m_l[8]}}, r_m_l}) * $signed({10'd0, r_g_l});
    assign w_prod_r = $signed({{10{r_m_r[8]}}, r_m_r}) * $signed({10'd0, r_g_r});

    assign BASS   = r_bass;
    assign TREBLE = r_treble;

    always_ff @(posedge clk32) begin
        if (!resb) begin
            r_mix     <= LMC_MIX_DEF;
            r_bass    <= LMC_TONE_DEF;
            r_treble  <= LMC_TONE_DEF;
            r_master  <= LMC_MASTER_DEF;
            r_left    <= LMC_LR_DEF;
            r_right   <= LMC_LR_DEF;
            r_v1      <= 1'b0;
            r_m_l     <= '0;
            r_m_r     <= '0;
            r_g_l     <= '0;
            r_g_r     <= '0;
            OUT_L     <= '0;
            OUT_R     <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            if (w_cmd_valid) begin
                case (w_fn)
                    LMC_FN_MIX:    r_mix    <= w_val[1:0];
                    LMC_FN_BASS:   r_bass   <= 4'(lmc_clip(w_val, LMC_TONE_MAX));
                    LMC_FN_TREBLE: r_treble <= 4'(lmc_clip(w_val, LMC_TONE_MAX));
                    LMC_FN_MASTER: r_master <= lmc_clip(w_val, LMC_MASTER_MAX);
                    LMC_FN_RIGHT:  r_right  <= lmc_clip(w_val, LMC_LR_MAX);
                    LMC_FN_LEFT:   r_left   <= lmc_clip(w_val, LMC_LR_MAX);
                    default: ;
                endcase
            end

            // Gains are frozen with the sample so later register writes cannot touch it
            r_v1 <= SAMPLE_EN;
            if (SAMPLE_EN) begin
                r_m_l <= w_m_l;
                r_m_r <= w_m_r;
                r_g_l <= lmc_gain(w_att_l);
                r_g_r <= lmc_gain(w_att_r);
            end

            OUT_VALID <= r_v1;
            if (r_v1) begin
                OUT_L <= lmc_sat(w_prod_l);
                OUT_R <= lmc_sat(w_prod_r);
            end
        end
    end

endmodule

// File: tb/tb_lmc_audio_mixer.sv
// Bench for lmc_audio_mixer: directed scenarios plus random commands/samples against a behavioural model.
module tb_lmc_audio_mixer;

    logic        clk32 = 1'b0;
    logic        resb;
    logic        MW_CLK, MW_DATA, MW_DONE, SAMPLE_EN;
    logic [7:0]  DMA_L, DMA_R, PSG_IN;
    logic [15:0] OUT_L, OUT_R;
    logic        OUT_VALID;
    logic [3:0]  BASS, TREBLE;

    lmc_audio_mixer dut (
        .clk32     (clk32),
        .resb      (resb),
        .MW_CLK    (MW_CLK),
        .MW_DATA   (MW_DATA),
        .MW_DONE   (MW_DONE),
        .SAMPLE_EN (SAMPLE_EN),
        .DMA_L     (DMA_L),
        .DMA_R     (DMA_R),
        .PSG_IN    (PSG_IN),
        .OUT_L     (OUT_L),
        .OUT_R     (OUT_R),
        .OUT_VALID (OUT_VALID),
        .BASS      (BASS),
        .TREBLE    (TREBLE)
    );

    always #5 clk32 = ~clk32;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_l = 0;
    int last_r = 0;

    int m_mix, m_bass, m_treble, m_master, m_left, m_right;

    typedef struct {
        int due;
        int l;
        int r;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(posedge clk32) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Gain straight from the dB law rather than a table
    function automatic int ref_gain(input int n);
        real g;
        if (n >= 40) return 0;
        g = 256.0 * (10.0 ** (-real'(n) / 10.0));
        return $rtoi(g + 0.5);
    endfunction

    function automatic int ref_chan(input int d, input int psg, input int att);
        int s, p, m, y;
        s = d - 128;
        p = psg - 128;
        case (m_mix)
            1:       m = s + p;
            0:       m = s + ((p >= 0) ? p / 4 : -((3 - p) / 4));
            default: m = s;
        endcase
        y = m * ref_gain(att);
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        return y;
    endfunction

    function automatic int att_l();
        return (40 - m_master) + (20 - m_left);
    endfunction

    function automatic int att_r();
        return (40 - m_master) + (20 - m_right);
    endfunction

    function automatic int lim(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic void model_reset();
        m_mix = 1; m_bass = 6; m_treble = 6; m_master = 40; m_left = 20; m_right = 20;
    endfunction

    // A command counts only with at least 11 bits, judged on the last 11
    function automatic void model_cmd(input int word, input int nbits);
        int w, fn, val;
        w = word & 'h7ff;
        if (nbits < 11 || ((w >> 9) & 3) != 2) return;
        fn  = (w >> 6) & 7;
        val = w & 63;
        case (fn)
            0: m_mix    = val & 3;
            1: m_bass   = lim(val, 12);
            2: m_treble = lim(val, 12);
            3: m_master = lim(val, 40);
            4: m_right  = lim(val, 20);
            5: m_left   = lim(val, 20);
            default: ;
        endcase
    endfunction

    // Each OUT_VALID must line up with a queued expectation exactly two cycles after its strobe
    always @(negedge clk32) begin
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            mon_e = exp_q.pop_front();
            chk("out_valid", OUT_VALID, 1);
            chk("out_l", $signed(OUT_L), mon_e.l);
            chk("out_r", $signed(OUT_R), mon_e.r);
            last_l = $signed(OUT_L);
            last_r = $signed(OUT_R);
        end else if (OUT_VALID !== 1'b0) begin
            chk("spurious_valid", OUT_VALID, 0);
        end
    end

    task automatic strobe(input logic [7:0] dl, input logic [7:0] dr, input logic [7:0] ps,
                          input bit expect_out);
        exp_t e;
        @(negedge clk32);
        DMA_L = dl; DMA_R = dr; PSG_IN = ps; SAMPLE_EN = 1'b1;
        if (expect_out) begin
            e.due = cyc + 2;
            e.l   = ref_chan(int'(dl), int'(ps), att_l());
            e.r   = ref_chan(int'(dr), int'(ps), att_r());
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk32);
        SAMPLE_EN = 1'b0;
        repeat (n) @(negedge clk32);
    endtask

    task automatic mw_shift(input int word, input int nbits, input bit with_done);
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge clk32);
            SAMPLE_EN = 1'b0;
            MW_DATA   = ((word >> i) & 1) != 0;
            MW_CLK    = 1'b1;
            if (with_done && i == 0) MW_DONE = 1'b1;
            @(negedge clk32);
            MW_CLK = 1'b0;
        end
    endtask

    task automatic mw_cmd(input int word, input int nbits, input bit together);
        mw_shift(word, nbits, together);
        if (!together) begin
            @(negedge clk32);
            MW_DONE = 1'b1;
        end
        @(negedge clk32);
        MW_DONE = 1'b0;
        repeat (3) @(negedge clk32);
        model_cmd(word, nbits);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, word, k;
        resb = 1'b0; MW_CLK = 1'b0; MW_DATA = 1'b0; MW_DONE = 1'b0; SAMPLE_EN = 1'b0;
        DMA_L = 8'h80; DMA_R = 8'h80; PSG_IN = 8'h80;
        model_reset();
        repeat (3) @(negedge clk32);
        resb = 1'b1;
        @(negedge clk32);

        chk("rst_out_l", $signed(OUT_L), 0);
        chk("rst_out_r", $signed(OUT_R), 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_bass", BASS, 6);
        chk("rst_treble", TREBLE, 6);

        // Default volume, PSG silent: full-scale gain
        strobe(8'hC0, 8'hC0, 8'h80, 1);
        idle(4);
        chk("t1_l", last_l, 16384);
        chk("t1_r", last_r, 16384);

        // master = 30 -> 10 steps of attenuation
        mw_cmd(11'b10_011_011110, 11, 0);
        strobe(8'hC0, 8'hC0, 8'h80, 1);
        idle(4);
        chk("t2_l", last_l, 1664);
        chk("t2_r", last_r, 1664);

        // Saturation at both rails
        mw_cmd(11'b10_011_101000, 11, 0);
        mw_cmd(11'b10_000_000001, 11, 0);
        strobe(8'hFF, 8'hFF, 8'hFF, 1);
        idle(4);
        chk("sat_hi", last_l, 32767);
        strobe(8'h00, 8'h00, 8'h00, 1);
        idle(4);
        chk("sat_lo", last_r, -32768);

        // Wrong address, short transfer, then a 12-bit transfer using its last 11 bits
        mw_cmd(11'b01_011_000000, 11, 0);
        mw_cmd(10'b10_011_0000, 10, 0);
        mw_cmd(12'b1_10_101_001010, 12, 0);
        strobe(8'hC0, 8'hC0, 8'h80, 1);
        idle(4);
        chk("t4_l", last_l, 1664);
        chk("t4_r", last_r, 16384);

        // Value clamps and full mute
        mw_cmd(11'b10_001_111111, 11, 0);
        chk("bass_clamp", BASS, 12);
        mw_cmd(11'b10_101_000000, 11, 0);
        mw_cmd(11'b10_011_000000, 11, 0);
        strobe(8'hF0, 8'h35, 8'hE0, 1);
        idle(4);
        chk("mute_l", last_l, 0);

        // Reset in the middle of a transfer, then mid-pipeline
        mw_shift(11'b10_011_000000, 6, 0);
        @(negedge clk32);
        resb = 1'b0;
        @(negedge clk32);
        resb = 1'b1;
        model_reset();
        mw_cmd(5'b10_011, 5, 0);
        strobe(8'hC0, 8'hC0, 8'h80, 0);
        @(negedge clk32);
        SAMPLE_EN = 1'b0;
        resb = 1'b0;
        @(negedge clk32);
        chk("rst_no_valid", OUT_VALID, 0);
        chk("rst2_out_l", $signed(OUT_L), 0);
        chk("rst2_bass", BASS, 6);
        resb = 1'b1;
        model_reset();
        idle(3);
        strobe(8'hC0, 8'hC0, 8'h80, 1);
        idle(4);
        chk("post_rst_l", last_l, 16384);

        // Fresh command with last bit and done rising together; right = 5
        mw_cmd(11'b10_100_000101, 11, 1);
        strobe(8'hC0, 8'hC0, 8'h80, 1);
        idle(4);
        chk("together_r", last_r, 64 * 8);

        // Quarter-level PSG mixing
        mw_cmd(11'b10_000_000000, 11, 0);
        strobe(8'hC0, 8'hC0, 8'h00, 1);
        idle(4);
        chk("mix00_l", last_l, 8192);

        // Random commands and bursts of samples
        for (int it = 0; it < 60; it++) begin
            nb   = $urandom_range(13, 9);
            word = ($urandom & 'h3) << 11;
            word |= (($urandom_range(3, 0) == 0) ? int'($urandom & 3) : 2) << 9;
            word |= int'($urandom & 7) << 6;
            word |= int'($urandom & 63);
            mw_cmd(word, nb, bit'($urandom & 1));
            chk("rnd_bass", BASS, m_bass);
            chk("rnd_treble", TREBLE, m_treble);
            k = $urandom_range(4, 1);
            for (int j = 0; j < k; j++)
                strobe(8'($urandom), 8'($urandom), 8'($urandom), 1);
            idle($urandom_range(3, 0));
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk32);
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
